// File: rtl/nmr_echo_capture_if.sv
// Sample stream from the echo capture FIFO towards the DMA/readout logic.
// A beat transfers on any clk edge where m_tvalid & m_tready; the master holds m_tdata/m_tlast stable while m_tvalid & ~m_tready.
interface nmr_echo_capture_if;
    logic [15:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;

    modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
    modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);
endinterface

// File: rtl/nmr_echo_capture.sv
// Opens one ADC capture window after each receiver-blanking interval, decimates the samples
// and streams them (last sample of a window tagged) through a first-word-fall-through FIFO.
module nmr_echo_capture #(
    parameter int US_DIVIDER = 125,
    parameter int ADC_WIDTH  = 14,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sync_in,
    input  logic                        blank_in,
    input  logic signed [ADC_WIDTH-1:0] adc_in,
    input  logic [15:0]                 decim_in,
    input  logic [31:0]                 acq_dly_in,
    input  logic [15:0]                 acq_len_in,
    input  logic [15:0]                 max_windows_in,
    nmr_echo_capture_if.master          m_axis,
    output logic [15:0]                 window_cnt,
    output logic                        overflow,
    output logic                        busy,
    output logic [1:0]                  state_dbg
);
    localparam int PW = (US_DIVIDER > 1) ? $clog2(US_DIVIDER) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW-1:0] PRESC_TOP = PW'(US_DIVIDER - 1);
    localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        DELAY   = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t        state;
    logic          sync_prv;
    logic          blank_prv;
    logic [PW-1:0] presc;
    logic [31:0]   us_cnt;
    logic [15:0]   dec_cnt;
    logic [15:0]   idx;

    // Each entry holds {tlast, sign-extended sample}.
    logic [16:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic        sync_rise;
    logic        blank_fall;
    logic        sample_now;
    logic        last_now;
    logic        full;
    logic        pop;
    logic        push_ok;
    logic [16:0] push_word;
    logic [16:0] head_word;

    assign sync_rise  = sync_in & ~sync_prv;
    assign blank_fall = ~blank_in & blank_prv;

    // A restart on the same edge abandons the sample that would otherwise be taken.
    assign sample_now = (state == CAPTURE) && (dec_cnt == 16'd0) && !sync_rise;
    assign last_now   = (idx == (acq_len_in - 16'd1));
    assign push_word  = {last_now, 16'(adc_in)};

    assign full    = (count == FIFO_FULL);
    assign pop     = m_axis.m_tvalid & m_axis.m_tready;
    assign push_ok = sample_now & (~full | pop);

    assign head_word       = fifo_mem[rd_ptr];
    assign m_axis.m_tvalid = (count != '0);
    assign m_axis.m_tdata  = m_axis.m_tvalid ? head_word[15:0] : 16'd0;
    assign m_axis.m_tlast  = m_axis.m_tvalid & head_word[16];

    assign busy      = (state == DELAY) || (state == CAPTURE);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= push_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sync_prv   <= 1'b0;
            blank_prv  <= 1'b0;
            presc      <= '0;
            us_cnt     <= '0;
            dec_cnt    <= '0;
            idx        <= '0;
            window_cnt <= '0;
            overflow   <= 1'b0;
        end else begin
            sync_prv  <= sync_in;
            blank_prv <= blank_in;
            if (sample_now && full && !pop) begin
                overflow <= 1'b1;
            end
            if (sync_rise) begin
                state      <= ARMED;
                window_cnt <= '0;
                overflow   <= 1'b0;
            end else begin
                case (state)
                    IDLE: ;
                    ARMED: begin
                        if (blank_fall && (acq_len_in != 16'd0)) begin
                            state  <= DELAY;
                            presc  <= PRESC_TOP;
                            us_cnt <= '0;
                        end
                    end
                    DELAY: begin
                        if (us_cnt == acq_dly_in) begin
                            state   <= CAPTURE;
                            dec_cnt <= '0;
                            idx     <= '0;
                        end else if (presc == '0) begin
                            presc  <= PRESC_TOP;
                            us_cnt <= us_cnt + 32'd1;
                        end else begin
                            presc <= presc - 1'b1;
                        end
                    end
                    CAPTURE: begin
                        if (dec_cnt == 16'd0) begin
                            // Gap to the next sample uses the decimation value live at this sample.
                            dec_cnt <= (decim_in == 16'd0) ? 16'd0 : (decim_in - 16'd1);
                            if (last_now) begin
                                window_cnt <= window_cnt + 16'd1;
                                if ((max_windows_in != 16'd0) &&
                                    ((window_cnt + 16'd1) == max_windows_in)) begin
                                    state <= IDLE;
                                end else begin
                                    state <= ARMED;
                                end
                            end else begin
                                idx <= idx + 16'd1;
                            end
                        end else begin
                            dec_cnt <= dec_cnt - 16'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_nmr_echo_capture.sv
// Self-checking bench for nmr_echo_capture: window schedules are computed arithmetically at each
// accepted blank fall and replayed into a queue-based stream model that is compared every cycle.
module tb_nmr_echo_capture;
  localparam int US    = 4;
  localparam int DEPTH = 4;

  typedef struct {
    int e;
    bit last;
  } sched_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               sync_in;
  logic               blank_in;
  logic signed [13:0] adc_in;
  logic [15:0]        decim;
  logic [31:0]        dly;
  logic [15:0]        len;
  logic [15:0]        maxw;
  logic [15:0]        window_cnt;
  logic               overflow;
  logic               busy;
  logic [1:0]         state_dbg;
  bit                 rand_ready;
  bit                 ready_fix;

  nmr_echo_capture_if bus ();

  nmr_echo_capture #(.US_DIVIDER(US), .ADC_WIDTH(14), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .sync_in(sync_in), .blank_in(blank_in), .adc_in(adc_in),
    .decim_in(decim), .acq_dly_in(dly), .acq_len_in(len), .max_windows_in(maxw),
    .m_axis(bus), .window_cnt(window_cnt), .overflow(overflow), .busy(busy),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial forever #5 clk = ~clk;

  // ---------------- model state ----------------
  int          edge_n = 0;
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [16:0] exp_q[$];
  sched_t      sched[$];
  int          beat_e[$];
  logic [16:0] beat_w[$];
  logic [13:0] adc_log[int];
  bit          m_armed, m_active, m_ovf, m_sprv, m_bprv;
  int          m_cap_edge;
  logic [15:0] m_wcnt;

  function automatic logic [15:0] sext(input logic [13:0] v);
    return {{2{v[13]}}, v};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", name, edge_n, act, exp);
    end
  endtask

  task automatic model_step();
    bit          sr, bf, pop;
    sched_t      s;
    logic [16:0] w;
    int          start, stp;
    adc_log[edge_n] = adc_in;
    if (rst) begin
      exp_q.delete(); sched.delete();
      m_armed = 0; m_active = 0; m_ovf = 0; m_sprv = 0; m_bprv = 0; m_wcnt = '0;
      return;
    end
    sr = sync_in & ~m_sprv;
    bf = ~blank_in & m_bprv;
    m_sprv = sync_in;
    m_bprv = blank_in;
    pop = (exp_q.size() != 0) && bus.m_tready;
    if (pop) begin
      beat_e.push_back(edge_n);
      beat_w.push_back(exp_q[0]);
      void'(exp_q.pop_front());
    end
    if (sr) begin
      sched.delete(); m_active = 0; m_armed = 1; m_wcnt = '0; m_ovf = 0;
    end else if (sched.size() != 0 && sched[0].e == edge_n) begin
      s = sched.pop_front();
      w = {s.last, sext(adc_in)};
      if (exp_q.size() < DEPTH) exp_q.push_back(w);
      else m_ovf = 1;
      if (s.last) begin
        m_wcnt = m_wcnt + 16'd1;
        m_active = 0;
        m_armed = !((maxw != 0) && (m_wcnt == maxw));
      end
    end else if (bf && m_armed && !m_active && len != 0) begin
      start = edge_n + 2 + US * int'(dly);
      stp = (decim == 0) ? 1 : int'(decim);
      for (int i = 0; i < int'(len); i++) sched.push_back('{e: start + i * stp, last: (i == int'(len) - 1)});
      m_active = 1;
      m_cap_edge = edge_n + 1 + US * int'(dly);
    end
  endtask

  // ---------------- model + compare, #1 after each active edge ----------------
  initial forever begin
    logic [1:0] st_exp;
    @(posedge clk);
    #1;
    edge_n++;
    model_step();
    st_exp = m_active ? ((edge_n >= m_cap_edge) ? 2'd3 : 2'd2) : (m_armed ? 2'd1 : 2'd0);
    check("tvalid", 32'(bus.m_tvalid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("tdata", 32'(bus.m_tdata), 32'(exp_q[0][15:0]));
      check("tlast", 32'(bus.m_tlast), 32'(exp_q[0][16]));
    end
    check("window_cnt", 32'(window_cnt), 32'(m_wcnt));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("busy", 32'(busy), 32'(m_active));
    check("state", 32'(state_dbg), 32'(st_exp));
  end

  // ---------------- drivers ----------------
  always @(posedge clk) begin
    #2;
    adc_in = 14'($urandom);
    bus.m_tready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fix;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_sync();
    step();
    sync_in = 1'b1;
    step();
    sync_in = 1'b0;
  endtask

  task automatic fall_blank(input int hi, output int f);
    step();
    blank_in = 1'b1;
    step(hi);
    blank_in = 1'b0;
    f = edge_n + 1;
    step();
  endtask

  task automatic set_params(input int d, input int dc, input int l, input int mx);
    dly = 32'(d); decim = 16'(dc); len = 16'(l); maxw = 16'(mx);
  endtask

  task automatic clear_log();
    beat_e.delete();
    beat_w.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int f, f2, nlast, hi, nf;
    rst = 1'b1; sync_in = 1'b0; blank_in = 1'b0; adc_in = '0;
    rand_ready = 0; ready_fix = 1; bus.m_tready = 1'b1;
    set_params(0, 1, 4, 1);
    step(4);
    check("rst_tvalid", 32'(bus.m_tvalid), 0);
    check("rst_tdata", 32'(bus.m_tdata), 0);
    check("rst_window_cnt", 32'(window_cnt), 0);
    check("rst_state", 32'(state_dbg), 0);
    rst = 1'b0;
    step(2);

    // Basic window: beats at f+3..f+6 carrying adc sampled at f+2..f+5.
    pulse_sync();
    check("basic_armed", 32'(state_dbg), 1);
    clear_log();
    fall_blank(10, f);
    step(12);
    check("basic_beats", beat_e.size(), 4);
    for (int i = 0; i < beat_e.size() && i < 4; i++) begin
      check("basic_beat_edge", beat_e[i], f + 3 + i);
      check("basic_beat_last", 32'(beat_w[i][16]), 32'(i == 3));
      check("basic_beat_data", 32'(beat_w[i][15:0]), 32'(sext(adc_log[f + 2 + i])));
    end
    check("basic_window_cnt", 32'(window_cnt), 1);
    check("basic_idle", 32'(state_dbg), 0);

    // Delay 3 us at 4 clk/us, decimation 5.
    set_params(3, 5, 3, 0);
    pulse_sync();
    clear_log();
    fall_blank(3, f);
    step(40);
    check("dly_beats", beat_e.size(), 3);
    for (int i = 0; i < beat_e.size() && i < 3; i++) begin
      check("dly_beat_edge", beat_e[i], f + 15 + 5 * i);
      check("dly_beat_last", 32'(beat_w[i][16]), 32'(i == 2));
    end

    // Three windows allowed, fourth fall ignored.
    set_params(0, 2, 2, 3);
    pulse_sync();
    clear_log();
    repeat (4) begin
      fall_blank(3, f);
      step(12);
    end
    check("multi_beats", beat_e.size(), 6);
    nlast = 0;
    foreach (beat_w[i]) nlast += int'(beat_w[i][16]);
    check("multi_tlast", nlast, 3);
    check("multi_window_cnt", 32'(window_cnt), 3);
    check("multi_idle", 32'(state_dbg), 0);

    // Backpressure: four words held, the rest dropped, last one lost.
    set_params(0, 1, 8, 0);
    ready_fix = 0;
    pulse_sync();
    clear_log();
    fall_blank(3, f);
    step(15);
    check("bp_overflow", 32'(overflow), 1);
    check("bp_tvalid", 32'(bus.m_tvalid), 1);
    check("bp_no_beats", beat_e.size(), 0);
    ready_fix = 1;
    step(8);
    check("bp_beats", beat_e.size(), 4);
    nlast = 0;
    foreach (beat_w[i]) nlast += int'(beat_w[i][16]);
    check("bp_tlast", nlast, 0);
    pulse_sync();
    check("bp_overflow_clear", 32'(overflow), 0);

    // Restart after two of four samples.
    set_params(0, 3, 4, 0);
    ready_fix = 0;
    pulse_sync();
    clear_log();
    fall_blank(3, f);
    for (int k = 0; k < 20 && edge_n < f + 5; k++) step();
    sync_in = 1'b1;
    step();
    sync_in = 1'b0;
    check("restart_armed", 32'(state_dbg), 1);
    check("restart_window_cnt", 32'(window_cnt), 0);
    step(10);
    ready_fix = 1;
    step(5);
    check("restart_beats", beat_e.size(), 2);
    for (int i = 0; i < beat_e.size() && i < 2; i++) begin
      check("restart_beat_last", 32'(beat_w[i][16]), 0);
      check("restart_beat_data", 32'(beat_w[i][15:0]), 32'(sext(adc_log[f + 2 + 3 * i])));
    end

    // Reset during DELAY with words queued.
    set_params(0, 1, 2, 0);
    ready_fix = 0;
    pulse_sync();
    fall_blank(3, f);
    step(8);
    dly = 32'd3;
    fall_blank(3, f2);
    for (int k = 0; k < 20 && edge_n < f2 + 3; k++) step();
    rst = 1'b1;
    step();
    check("mrst_tvalid", 32'(bus.m_tvalid), 0);
    check("mrst_tdata", 32'(bus.m_tdata), 0);
    check("mrst_tlast", 32'(bus.m_tlast), 0);
    check("mrst_window_cnt", 32'(window_cnt), 0);
    check("mrst_overflow", 32'(overflow), 0);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_state", 32'(state_dbg), 0);
    rst = 1'b0;
    ready_fix = 1;
    clear_log();
    fall_blank(3, f);
    step(30);
    check("mrst_no_capture", beat_e.size(), 0);
    check("mrst_still_idle", 32'(state_dbg), 0);

    // Randomised windows, falls, restarts and backpressure.
    rand_ready = 1;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) pulse_sync();
      set_params($urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 3));
      nf = $urandom_range(1, 3);
      for (int j = 0; j < nf; j++) begin
        hi = $urandom_range(1, 4);
        fall_blank(hi, f);
        step($urandom_range(2, 20));
        if ($urandom_range(0, 4) == 0) pulse_sync();
      end
      step(30);
    end
    rand_ready = 0;
    ready_fix = 1;
    step(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
